// File: rtl/cordic_arg_reducer.sv
// Angle front end and result fix-up around a pipelined rotation-mode CORDIC core.
// Define ARG_RED_ERR_EN to build the sticky tag-underflow flag on err.
module cordic_arg_reducer #(
   parameter int               WIDTH     = 32,
   parameter int               FRAC      = 29,
   parameter int               TAG_DEPTH = 16,
   parameter logic [WIDTH-1:0] X_INIT    = 32'h136E9DB3,
   parameter logic [WIDTH-1:0] PI_Q      = 32'h6487ED51
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_angle,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z,
   output logic             mode,
   output logic             valid_in,
   input  logic [WIDTH-1:0] cos,
   input  logic [WIDTH-1:0] sin,
   input  logic             valid_out,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_cos,
   output logic [WIDTH-1:0] res_sin,
   output logic             err
);

   localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CW = AW + 1;

   if (FRAC >= WIDTH || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_param_check
      $error("cordic_arg_reducer: FRAC must be below WIDTH and TAG_DEPTH a power of 2");
   end

   logic [CW-1:0]        count_q, count_d;
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [TAG_DEPTH-1:0] tag_mem_q;
   logic                 push, pop, tag_out;

   // A pop frees a slot in the same cycle, so a full FIFO can still take a new angle.
   assign pop      = valid_out & (count_q != '0);
   assign in_ready = (count_q < CW'(TAG_DEPTH)) | pop;
   assign push     = in_valid & in_ready;
   assign tag_out  = pop & tag_mem_q[rd_ptr_q];

   // NOTE: combinational blocks assign every output first so no path leaves a latch behind.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // NOTE: tag storage has no reset; count and pointers alone decide which entries are live.
   // The tag is queued at accept so occupancy already covers the sample sitting in S1.
   always_ff @(posedge clk) begin
      if (push) tag_mem_q[wr_ptr_q] <= in_angle[WIDTH-1] ^ in_angle[WIDTH-2];
   end

   logic                 s1_valid_q;
   logic [WIDTH-1:0]     s1_angle_q, s1_fold;
   logic [2*WIDTH-1:0]   prod;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_angle_q <= '0;
      end else begin
         s1_valid_q <= push;
         if (push) s1_angle_q <= in_angle;
      end
   end

   // Quadrants 01/10 move by pi: flipping the sign bit adds pi with wrap-around.
   always_comb begin
      s1_fold = s1_angle_q;
      if (s1_angle_q[WIDTH-1] ^ s1_angle_q[WIDTH-2]) s1_fold[WIDTH-1] = ~s1_angle_q[WIDTH-1];
   end

   assign prod = {{WIDTH{s1_fold[WIDTH-1]}}, s1_fold} * {{WIDTH{PI_Q[WIDTH-1]}}, PI_Q};

   logic             valid_in_q;
   logic [WIDTH-1:0] x_q, y_q, z_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_in_q <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
      end else begin
         valid_in_q <= s1_valid_q;
         if (s1_valid_q) begin
            x_q <= X_INIT;
            y_q <= '0;
            z_q <= prod[2*WIDTH-2:WIDTH-1];
         end
      end
   end

   assign x        = x_q;
   assign y        = y_q;
   assign z        = z_q;
   assign valid_in = valid_in_q;
   assign mode     = 1'b0;

   function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] min_neg;
      min_neg = {1'b1, {(WIDTH-1){1'b0}}};
      return (v == min_neg) ? ~min_neg : (~v + WIDTH'(1));
   endfunction

   logic             res_valid_q;
   logic [WIDTH-1:0] res_cos_q, res_cos_d, res_sin_q, res_sin_d;

   assign res_cos_d = tag_out ? sat_neg(cos) : cos;
   assign res_sin_d = tag_out ? sat_neg(sin) : sin;

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         res_cos_q   <= '0;
         res_sin_q   <= '0;
      end else begin
         res_valid_q <= valid_out;
         if (valid_out) begin
            res_cos_q <= res_cos_d;
            res_sin_q <= res_sin_d;
         end
      end
   end

   assign res_valid = res_valid_q;
   assign res_cos   = res_cos_q;
   assign res_sin   = res_sin_q;

`ifdef ARG_RED_ERR_EN
   logic err_q;
   always_ff @(posedge clk) begin
      if (rst)                             err_q <= 1'b0;
      else if (valid_out && count_q == '0) err_q <= 1'b1;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_arg_reducer.sv
// Randomized bench for cordic_arg_reducer with an arithmetic reference model and a
// fixed-latency CORDIC core stand-in.
module tb_cordic_arg_reducer;

   localparam int          DEPTH  = 16;
   localparam logic [31:0] X_INIT = 32'h136E9DB3;
   localparam longint      PI_Q_L = 64'sh6487ED51;
   localparam longint      HALF   = 64'sd2147483648;
   localparam longint      QUART  = 64'sd1073741824;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, mode, valid_in, valid_out, res_valid, err;
   logic [31:0] in_angle, x, y, z, cos_v, sin_v, res_cos, res_sin;

   cordic_arg_reducer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
      .x(x), .y(y), .z(z), .mode(mode), .valid_in(valid_in),
      .cos(cos_v), .sin(sin_v), .valid_out(valid_out),
      .res_valid(res_valid), .res_cos(res_cos), .res_sin(res_sin), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   typedef struct { logic [31:0] angle; logic [31:0] c; logic [31:0] s; } stim_t;
   typedef struct { int due; logic [31:0] z; logic [31:0] c; logic [31:0] s; } vin_t;
   typedef struct { int due; logic [31:0] c; logic [31:0] s; } ret_t;

   stim_t dir_q[$];
   vin_t  exp_vin[$];
   ret_t  core_q[$];
   ret_t  exp_res[$];
   bit    tags[$];
   stim_t cur;
   bit    have_cur, model_err, armed, just_reset, stall_watch;
   int    cyc, lat, n_acc, first_stall_acc;

   // Fold to [-pi/2, pi/2) by adding or subtracting pi in plain integer BAM units.
   function automatic longint fold_angle(input logic [31:0] ang);
      longint a;
      a = longint'($signed(ang));
      if (a >= QUART)       a = a - HALF;
      else if (a < -QUART)  a = a + HALF;
      return a;
   endfunction

   function automatic logic [31:0] model_z(input logic [31:0] ang);
      longint p, q;
      p = fold_angle(ang) * PI_Q_L;
      q = p / HALF;
      if (p < 0 && (p % HALF) != 0) q = q - 1;
      return q[31:0];
   endfunction

   function automatic logic [31:0] sat_neg(input logic [31:0] v);
      longint n;
      n = -longint'($signed(v));
      if (n > 64'sd2147483647) n = 64'sd2147483647;
      return n[31:0];
   endfunction

   function automatic logic [31:0] rand_angle();
      logic [31:0] edges [8] = '{32'h4000_0000, 32'h3FFF_FFFF, 32'hBFFF_FFFF, 32'hC000_0000,
                                 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 7)];
      return $urandom;
   endfunction

   function automatic logic [31:0] rand_res();
      if ($urandom_range(0, 7) == 0) return 32'h8000_0000;
      return $urandom;
   endfunction

   // One clock: check registered outputs at negedge, drive inputs, check in_ready, update model.
   task automatic cycle(input bit offer, input bit do_rst, input bit force_vout);
      vin_t ve;
      ret_t re, ce;
      bit   t, exp_ready, neg;
      @(negedge clk);
      if (armed) begin
         if (just_reset) begin
            check("rst_x", x, 0);             check("rst_y", y, 0);
            check("rst_z", z, 0);             check("rst_mode", mode, 0);
            check("rst_res_cos", res_cos, 0); check("rst_res_sin", res_sin, 0);
            just_reset = 0;
         end
         if (exp_vin.size() > 0 && exp_vin[0].due == cyc) begin
            ve = exp_vin.pop_front();
            check("valid_in", valid_in, 1);
            check("z", z, ve.z);
            check("x", x, X_INIT);
            check("y", y, 0);
            core_q.push_back('{cyc + lat, ve.c, ve.s});
         end else check("valid_in_idle", valid_in, 0);
         if (exp_res.size() > 0 && exp_res[0].due == cyc) begin
            re = exp_res.pop_front();
            check("res_valid", res_valid, 1);
            check("res_cos", res_cos, re.c);
            check("res_sin", res_sin, re.s);
         end else check("res_valid_idle", res_valid, 0);
         check("err", err, model_err);
      end

      rst       = do_rst;
      valid_out = 1'b0;
      cos_v     = $urandom;
      sin_v     = $urandom;
      if (!do_rst && (force_vout || (core_q.size() > 0 && core_q[0].due == cyc))) begin
         if (force_vout) ce = '{cyc, rand_res(), rand_res()};
         else            ce = core_q.pop_front();
         valid_out = 1'b1;
         cos_v     = ce.c;
         sin_v     = ce.s;
      end
      if (offer && !have_cur) begin
         if (dir_q.size() > 0) cur = dir_q.pop_front();
         else                  cur = '{rand_angle(), rand_res(), rand_res()};
         have_cur = 1;
      end
      in_valid = offer && !do_rst;
      in_angle = have_cur ? cur.angle : $urandom;
      #1;

      if (do_rst) begin
         exp_vin.delete(); core_q.delete(); exp_res.delete(); tags.delete();
         have_cur = 0; model_err = 0; armed = 1; just_reset = 1;
      end else begin
         exp_ready = (tags.size() < DEPTH) || (valid_out && tags.size() > 0);
         if (armed) check("in_ready", in_ready, exp_ready);
         if (stall_watch && in_ready === 1'b0 && first_stall_acc < 0) first_stall_acc = n_acc;
         if (valid_out) begin
            if (tags.size() > 0) t = tags.pop_front();
            else begin
               t = 0;
`ifdef ARG_RED_ERR_EN
               model_err = 1;
`endif
            end
            exp_res.push_back('{cyc + 1, t ? sat_neg(cos_v) : cos_v, t ? sat_neg(sin_v) : sin_v});
         end
         if (in_valid && in_ready) begin
            neg = (fold_angle(cur.angle) != longint'($signed(cur.angle)));
            tags.push_back(neg);
            exp_vin.push_back('{cyc + 2, model_z(cur.angle), cur.c, cur.s});
            have_cur = 0;
            n_acc++;
         end
      end
      cyc++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_vin.size() + core_q.size() + exp_res.size() + tags.size()) != 0 && n < 300) begin
         cycle(0, 0, 0);
         n++;
      end
      check("drain_empty", 32'(exp_vin.size() + core_q.size() + exp_res.size() + tags.size()), 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_angle = '0; valid_out = 1'b0; cos_v = '0; sin_v = '0;
      cyc = 0; lat = 5; n_acc = 0; first_stall_acc = -1;
      have_cur = 0; model_err = 0; armed = 0; just_reset = 0; stall_watch = 0;

      // Reset held two clocks, then idle outputs and in_ready checked.
      cycle(0, 1, 0);
      cycle(0, 1, 0);
      cycle(0, 0, 0);

      // Directed angles and core results, back to back.
      dir_q.push_back('{32'h2000_0000, 32'h16A0_9E66, 32'h16A0_9E66});
      dir_q.push_back('{32'h6000_0000, 32'h16A0_9E66, 32'hE95F_619A});
      dir_q.push_back('{32'h8000_0000, 32'h2000_0000, 32'h0000_0000});
      dir_q.push_back('{32'h8000_0000, 32'h8000_0000, 32'h8000_0000});
      repeat (12) cycle(1, 0, 0);
      drain();

      // Random traffic with gaps.
      repeat (400) cycle($urandom_range(0, 9) < 7, 0, 0);
      drain();

      // Core latency beyond the tag depth: in_ready must throttle and recover with pops.
      lat = 20; n_acc = 0; first_stall_acc = -1; stall_watch = 1;
      repeat (150) cycle(1, 0, 0);
      stall_watch = 0;
      drain();
      check("accepts_before_stall", 32'(first_stall_acc), 16);

      // Reset with samples in flight, then an orphan core result.
      repeat (5) cycle(1, 0, 0);
      cycle(0, 1, 0);
      cycle(0, 1, 0);
      cycle(0, 0, 1);
      repeat (4) cycle(0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
